// File: rtl/i_ddr_deser_if.sv
// i_ddr_deser_if: serial-in / parallel-out bundle for the input deserialiser.
// Ports: D (serial lanes), E (enable), BITSLIP (align request),
//        Q (parallel words), Q_VALID (one-cycle word strobe).
interface i_ddr_deser_if #(
    parameter int WIDTH = 1,
    parameter int RATIO = 4
);
    logic [WIDTH-1:0]       D;
    logic                   E;
    logic                   BITSLIP;
    logic [WIDTH*RATIO-1:0] Q;
    logic                   Q_VALID;

    // master: the serial source / word consumer side
    modport master (
        output D, E, BITSLIP,
        input  Q, Q_VALID
    );

    // slave: the deserialiser itself
    modport slave (
        input  D, E, BITSLIP,
        output Q, Q_VALID
    );
endinterface

// File: rtl/i_ddr_deser.sv
// i_ddr_deser: multi-lane DDR/SDR input deserialiser with bitslip alignment.
// Ports: C clock, R sync active-high reset, io (slave): D/E/BITSLIP in,
//        Q (lane l at Q[l*RATIO +: RATIO], MSB oldest) and Q_VALID out.
module i_ddr_deser #(
    parameter int WIDTH    = 1,
    parameter int RATIO    = 4,
    parameter bit DDR_MODE = 1'b1
) (
    input logic          C,
    input logic          R,
    i_ddr_deser_if.slave io
);
    // Shift events per word: pairs in DDR, single bits in SDR.
    localparam int TC = DDR_MODE ? RATIO / 2 : RATIO;
    // A window at offset RATIO-1 reaches back 2*RATIO-1 bits into the
    // post-shift history, so only the bits that can still be reached
    // after the next shift are stored.
    localparam int HN = 2 * RATIO - 1;
    localparam int HQ = DDR_MODE ? HN - 2 : HN - 1;
    localparam int CW = $clog2(RATIO + 1);
    localparam int OW = $clog2(RATIO);

    localparam logic [CW-1:0] CNT_LAST = CW'(TC - 1);
    localparam logic [OW-1:0] OFF_LAST = OW'(RATIO - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("i_ddr_deser: WIDTH must be in 1..32");
        end
        if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
            $error("i_ddr_deser: RATIO must be in 2..16");
        end
        if (DDR_MODE && (RATIO % 2 != 0)) begin : g_bad_odd
            $error("i_ddr_deser: RATIO must be even in DDR mode");
        end
    endgenerate

    logic [WIDTH-1:0][HQ-1:0] hist_q, hist_d;
    logic [WIDTH-1:0][HN-1:0] hist_nx;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OW-1:0]            off_q, off_d;
    logic                     bs_q, bs_d;
    logic [WIDTH*RATIO-1:0]   q_q, q_d;
    logic                     qv_q, qv_d;
    logic                     shift_en;

    generate
        if (DDR_MODE) begin : g_ddr
            logic [WIDTH-1:0] p_q, p_d;
            logic [WIDTH-1:0] n_q, n_d;
            logic             pv_q, pv_d;

            always_comb begin
                p_d  = io.D;
                n_d  = io.D;
                // a pair only counts if E was high when its first bit
                // was taken, so bits seen while disabled never leak in
                pv_d = io.E;
            end

            always_ff @(posedge C) begin
                if (R) begin
                    p_q  <= '0;
                    pv_q <= 1'b0;
                end else begin
                    p_q  <= p_d;
                    pv_q <= pv_d;
                end
            end

            always_ff @(negedge C) begin
                if (R) begin
                    n_q <= '0;
                end else begin
                    n_q <= n_d;
                end
            end

            // posedge bit is older than the following negedge bit
            always_comb begin
                for (int l = 0; l < WIDTH; l++) begin
                    hist_nx[l] = {hist_q[l], p_q[l], n_q[l]};
                end
            end

            assign shift_en = io.E & pv_q;
        end else begin : g_sdr
            always_comb begin
                for (int l = 0; l < WIDTH; l++) begin
                    hist_nx[l] = {hist_q[l], io.D[l]};
                end
            end

            assign shift_en = io.E;
        end
    endgenerate

    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        off_d  = off_q;
        q_d    = q_q;
        qv_d   = 1'b0;
        bs_d   = io.BITSLIP;

        if (shift_en) begin
            for (int l = 0; l < WIDTH; l++) begin
                hist_d[l] = hist_nx[l][HQ-1:0];
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                qv_d  = 1'b1;
                // the word is cut with the offset in force before any
                // slip requested on this same edge
                for (int l = 0; l < WIDTH; l++) begin
                    q_d[l*RATIO +: RATIO] = hist_nx[l][off_q +: RATIO];
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // edge detector always tracks BITSLIP; only enabled edges slip
        if (io.E && io.BITSLIP && !bs_q) begin
            off_d = (off_q == OFF_LAST) ? '0 : off_q + OW'(1);
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            hist_q <= '0;
            cnt_q  <= '0;
            off_q  <= '0;
            bs_q   <= 1'b0;
            q_q    <= '0;
            qv_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            bs_q   <= bs_d;
            q_q    <= q_d;
            qv_q   <= qv_d;
        end
    end

    assign io.Q       = q_q;
    assign io.Q_VALID = qv_q;
endmodule

// File: tb/tb_i_ddr_deser.sv
// tb_i_ddr_deser: bench for i_ddr_deser in DDR (W=1,R=4) and SDR (W=2,R=8).
// Ports: none; drives two DUT instances through their interfaces.
module tb_i_ddr_deser;
    logic clk;
    logic r_ddr;
    logic r_sdr;

    int checks = 0;
    int errors = 0;

    i_ddr_deser_if #(.WIDTH(1), .RATIO(4)) ddr_if ();
    i_ddr_deser_if #(.WIDTH(2), .RATIO(8)) sdr_if ();

    i_ddr_deser #(.WIDTH(1), .RATIO(4), .DDR_MODE(1'b1)) u_ddr (
        .C  (clk),
        .R  (r_ddr),
        .io (ddr_if.slave)
    );

    i_ddr_deser #(.WIDTH(2), .RATIO(8), .DDR_MODE(1'b0)) u_sdr (
        .C  (clk),
        .R  (r_sdr),
        .io (sdr_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0]  ddr_exp[$];
    logic [15:0] sdr_exp[$];

    // reference model of the DDR W=1 R=4 lane
    logic [7:0] m_hist = '0;
    int         m_cnt  = 0;
    int         m_off  = 0;
    bit         m_bs   = 1'b0;
    bit         m_pp   = 1'b0;
    bit         m_pn   = 1'b0;
    bit         m_pv   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // one DDR cycle: called at a negedge, returns at the next negedge
    task automatic run_ddr(input bit p, input bit n, input bit e,
                           input bit bs, input bit r);
        #1;
        ddr_if.D       = p;
        ddr_if.E       = e;
        ddr_if.BITSLIP = bs;
        r_ddr          = r;
        if (r) begin
            m_hist = '0;
            m_cnt  = 0;
            m_off  = 0;
            m_bs   = 1'b0;
            m_pp   = 1'b0;
            m_pv   = 1'b0;
        end else begin
            if (e && m_pv) begin
                m_hist = {m_hist[5:0], m_pp, m_pn};
                if (m_cnt == 1) begin
                    m_cnt = 0;
                    ddr_exp.push_back(m_hist[m_off +: 4]);
                end else begin
                    m_cnt++;
                end
            end
            if (e && bs && !m_bs) m_off = (m_off + 1) % 4;
            m_bs = bs;
            m_pp = p;
            m_pv = e;
        end
        m_pn = r ? 1'b0 : n;
        @(posedge clk);
        #1;
        ddr_if.D = n;
        @(negedge clk);
    endtask

    // repeating serial 1000 as pairs (1,0),(0,0); BITSLIP high for
    // the first bs_slots cycles
    task automatic pattern(input int npairs, input int bs_slots);
        for (int k = 0; k < 2 * npairs; k++) begin
            run_ddr((k % 2) == 0, 1'b0, 1'b1, k < bs_slots, 1'b0);
        end
    endtask

    task automatic run_sdr(input logic [1:0] d, input bit e, input bit r);
        #1;
        sdr_if.D = d;
        sdr_if.E = e;
        r_sdr    = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ddr_if.Q_VALID === 1'b1) begin
            if (ddr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ddr_sb unexpected word %b", ddr_if.Q);
            end else begin
                chk("ddr_sb", ddr_if.Q, ddr_exp.pop_front());
            end
        end
        if (sdr_if.Q_VALID === 1'b1) begin
            if (sdr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sdr_sb unexpected word %h", sdr_if.Q);
            end else begin
                chk("sdr_sb", sdr_if.Q, sdr_exp.pop_front());
            end
        end
    end

    typedef struct {
        bit         p;
        bit         n;
        bit         e;
        bit         bs;
        bit         r;
        bit         exp_v;
        logic [3:0] exp_q;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [7:0] l0;
        logic [7:0] l1;

        // reset with toggling data, then basic words, then enable gap
        tbl[0]  = '{1, 0, 1, 0, 1, 0, 4'b0000};
        tbl[1]  = '{0, 1, 1, 0, 1, 0, 4'b0000};
        tbl[2]  = '{1, 1, 1, 0, 1, 0, 4'b0000};
        tbl[3]  = '{1, 0, 1, 0, 0, 0, 4'b0000};
        tbl[4]  = '{1, 1, 1, 0, 0, 0, 4'b0000};
        tbl[5]  = '{0, 0, 1, 0, 0, 1, 4'b1011};
        tbl[6]  = '{1, 0, 1, 0, 0, 0, 4'b1011};
        tbl[7]  = '{1, 0, 1, 0, 0, 1, 4'b0010};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 4'b0010};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 4'b0010};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 4'b0010};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 4'b0010};
        tbl[12] = '{1, 1, 1, 0, 0, 0, 4'b0010};
        tbl[13] = '{0, 0, 1, 0, 0, 1, 4'b1011};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 4'b1011};

        r_ddr          = 1'b1;
        r_sdr          = 1'b1;
        ddr_if.D       = '0;
        ddr_if.E       = 1'b0;
        ddr_if.BITSLIP = 1'b0;
        sdr_if.D       = '0;
        sdr_if.E       = 1'b0;
        sdr_if.BITSLIP = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_ddr(tbl[i].p, tbl[i].n, tbl[i].e, tbl[i].bs, tbl[i].r);
            chk($sformatf("tbl_v[%0d]", i), ddr_if.Q_VALID, tbl[i].exp_v);
            chk($sformatf("tbl_q[%0d]", i), ddr_if.Q, tbl[i].exp_q);
        end

        // bitslip on stationary 1000 stream
        run_ddr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pattern(4, 0);
        chk("slip0", ddr_if.Q, 4'b1000);
        pattern(4, 1);
        chk("slip1", ddr_if.Q, 4'b0100);
        pattern(4, 1);
        chk("slip2", ddr_if.Q, 4'b0010);
        pattern(4, 1);
        chk("slip3", ddr_if.Q, 4'b0001);
        pattern(4, 1);
        chk("slip4_wrap", ddr_if.Q, 4'b1000);
        pattern(5, 5);
        chk("slip_held", ddr_if.Q, 4'b0100);
        pattern(4, 1);
        chk("slip_off2", ddr_if.Q, 4'b0010);

        // reset one pair into a word with offset 2
        run_ddr(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_q", ddr_if.Q, 4'b0000);
        chk("mid_rst_v", ddr_if.Q_VALID, 1'b0);
        run_ddr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_ddr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_ddr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_v", ddr_if.Q_VALID, 1'b1);
        chk("post_rst_q", ddr_if.Q, 4'b1101);
        #1;
        ddr_if.E = 1'b0;

        // SDR two lanes, MSB first
        run_sdr(2'b11, 1'b1, 1'b1);
        run_sdr(2'b01, 1'b1, 1'b1);
        chk("sdr_rst_q", sdr_if.Q, 16'h0000);
        chk("sdr_rst_v", sdr_if.Q_VALID, 1'b0);
        l0 = 8'hA5;
        l1 = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (i % 8 == 7) sdr_exp.push_back(16'h3CA5);
            run_sdr({l1[7 - (i % 8)], l0[7 - (i % 8)]}, 1'b1, 1'b0);
            chk($sformatf("sdr_v[%0d]", i), sdr_if.Q_VALID, i % 8 == 7);
        end
        chk("sdr_q", sdr_if.Q, 16'h3CA5);

        @(negedge clk);
        chk("ddr_sb_empty", ddr_exp.size(), 0);
        chk("sdr_sb_empty", sdr_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
